// File: rtl/muldiv_arbiter.sv
// Two-requester round-robin front end for a shared multiply/divide unit.
// One operation is in flight at a time: accept, issue, wait for the unit
// (with a timeout), then pulse a response back to the owning requester.
module muldiv_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mul,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_result,
  output logic [7:0]  rsp0_rem,
  output logic [2:0]  rsp0_flags,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mul,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_result,
  output logic [7:0]  rsp1_rem,
  output logic [2:0]  rsp1_flags,
  // mul/div unit
  output logic        md_start,
  output logic        md_multiply,
  output logic [7:0]  md_a,
  output logic [7:0]  md_b,
  input  logic [15:0] md_result,
  input  logic [7:0]  md_remainder,
  input  logic        md_result_valid,
  input  logic        md_divide_by_zero,
  input  logic        md_overflow,
  // status
  output logic        busy,
  output logic        grant_id
);

  // Last WAIT cycle before the timeout fires.
  localparam logic [7:0] TermCnt = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        op_mul_q, op_mul_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] res_q, res_d;
  logic [7:0]  rem_q, rem_d;
  logic [2:0]  flags_q, flags_d;

  logic accept;
  logic accept_id;

  // Round-robin arbitration; ready only in IDLE and never while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      accept_id = ~last_grant_q;
    end else if (req1_valid) begin
      accept_id = 1'b1;
    end
    if (rst_n && state_q == StIdle) begin
      req0_ready = req0_valid & ~accept_id;
      req1_ready = req1_valid & accept_id;
    end
  end

  assign accept = req0_ready | req1_ready;

  // Next-state logic: operation latching, wait counter and response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_mul_d     = op_mul_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    wait_cnt_d   = wait_cnt_q;
    res_d        = res_q;
    rem_d        = rem_q;
    flags_d      = flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StIssue;
          grant_d      = accept_id;
          last_grant_d = accept_id;
          op_mul_d     = accept_id ? req1_mul : req0_mul;
          op_a_d       = accept_id ? req1_a : req0_a;
          op_b_d       = accept_id ? req1_b : req0_b;
        end
      end
      StIssue: begin
        state_d    = StWait;
        wait_cnt_d = 8'd0;
      end
      StWait: begin
        // A result arriving on the terminal cycle wins over the timeout.
        if (md_result_valid) begin
          state_d = StRespond;
          res_d   = md_result;
          rem_d   = md_remainder;
          flags_d = {1'b0, md_divide_by_zero, md_overflow};
        end else if (wait_cnt_q == TermCnt) begin
          state_d = StRespond;
          res_d   = 16'hFFFF;
          rem_d   = 8'hFF;
          flags_d = 3'b100;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; pointer resets so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_mul_q     <= 1'b0;
      op_a_q       <= 8'd0;
      op_b_q       <= 8'd0;
      wait_cnt_q   <= 8'd0;
      res_q        <= 16'd0;
      rem_q        <= 8'd0;
      flags_q      <= 3'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_mul_q     <= op_mul_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      wait_cnt_q   <= wait_cnt_d;
      res_q        <= res_d;
      rem_q        <= rem_d;
      flags_q      <= flags_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;

  // Unit operands are only presented while an operation is in flight.
  assign md_start    = (state_q == StIssue);
  assign md_multiply = busy & op_mul_q;
  assign md_a        = {8{busy}} & op_a_q;
  assign md_b        = {8{busy}} & op_b_q;

  assign rsp0_valid  = (state_q == StRespond) & ~grant_q;
  assign rsp1_valid  = (state_q == StRespond) & grant_q;
  assign rsp0_result = res_q;
  assign rsp0_rem    = rem_q;
  assign rsp0_flags  = flags_q;
  assign rsp1_result = res_q;
  assign rsp1_rem    = rem_q;
  assign rsp1_flags  = flags_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a behavioural mul/div unit model.
module tb_muldiv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_mul;
  logic [7:0]  req0_a, req0_b;
  logic        rsp0_valid;
  logic [15:0] rsp0_result;
  logic [7:0]  rsp0_rem;
  logic [2:0]  rsp0_flags;
  logic        req1_valid, req1_ready, req1_mul;
  logic [7:0]  req1_a, req1_b;
  logic        rsp1_valid;
  logic [15:0] rsp1_result;
  logic [7:0]  rsp1_rem;
  logic [2:0]  rsp1_flags;
  logic        md_start, md_multiply;
  logic [7:0]  md_a, md_b;
  logic [15:0] md_result;
  logic [7:0]  md_remainder;
  logic        md_result_valid, md_divide_by_zero, md_overflow;
  logic        busy, grant_id;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mul(req0_mul),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_rem(rsp0_rem),
    .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mul(req1_mul),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_rem(rsp1_rem),
    .rsp1_flags(rsp1_flags),
    .md_start(md_start), .md_multiply(md_multiply), .md_a(md_a), .md_b(md_b),
    .md_result(md_result), .md_remainder(md_remainder),
    .md_result_valid(md_result_valid), .md_divide_by_zero(md_divide_by_zero),
    .md_overflow(md_overflow),
    .busy(busy), .grant_id(grant_id)
  );

  // Unit model: result appears unit_delay cycles after the ISSUE cycle ends;
  // unit_delay of 0 means the unit never answers.
  int unsigned unit_delay;
  logic        stray;
  logic [3:0]  ucnt = 4'd0;
  logic        unit_valid = 1'b0;
  logic [15:0] m_res, prod;
  logic [7:0]  m_rem;
  logic        m_dbz, m_ovf;

  always_comb begin
    prod  = {8'd0, md_a} * {8'd0, md_b};
    m_res = 16'd0;
    m_rem = 8'd0;
    m_dbz = 1'b0;
    m_ovf = 1'b0;
    if (md_multiply) begin
      if (prod > 16'd255) begin
        m_res = 16'h00FF;
        m_ovf = 1'b1;
      end else begin
        m_res = prod;
      end
    end else if (md_b == 8'd0) begin
      m_res = 16'hFFFF;
      m_rem = 8'hFF;
      m_dbz = 1'b1;
    end else begin
      m_res = {8'd0, md_a / md_b};
      m_rem = md_a % md_b;
    end
  end

  always @(posedge clk) begin
    unit_valid <= 1'b0;
    if (md_start && unit_delay != 0) begin
      ucnt              <= 4'(unit_delay);
      md_result         <= m_res;
      md_remainder      <= m_rem;
      md_divide_by_zero <= m_dbz;
      md_overflow       <= m_ovf;
    end else if (ucnt == 4'd1) begin
      unit_valid <= 1'b1;
      ucnt       <= 4'd0;
    end else if (ucnt > 4'd1) begin
      ucnt <= ucnt - 4'd1;
    end
  end

  assign md_result_valid = unit_valid | stray;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic id, input logic mul, input logic [7:0] a,
                       input logic [7:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_mul = mul; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_mul = mul; req0_a = a; req0_b = b;
    end
  endtask

  // Single uncontended operation with nominal unit latency; returns in IDLE at T+5.
  task automatic nominal(input string tag, input logic id, input logic mul,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] eres, input logic [7:0] erem,
                         input logic [2:0] eflg);
    cyc(); drive(id, mul, a, b); #1;
    chk({tag, " ready"}, id ? req1_ready : req0_ready, 1);
    chk({tag, " other ready"}, id ? req0_ready : req1_ready, 0);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    chk({tag, " md_start T+1"}, md_start, 1);
    chk({tag, " grant_id"}, grant_id, id);
    chk({tag, " md_a"}, md_a, a);
    chk({tag, " md_b"}, md_b, b);
    chk({tag, " md_multiply"}, md_multiply, mul);
    cyc();
    chk({tag, " md_start T+2"}, md_start, 0);
    cyc();
    chk({tag, " rsp T+3"}, id ? rsp1_valid : rsp0_valid, 0);
    cyc();
    chk({tag, " rsp T+4"}, id ? rsp1_valid : rsp0_valid, 1);
    chk({tag, " other rsp"}, id ? rsp0_valid : rsp1_valid, 0);
    chk({tag, " result"}, id ? rsp1_result : rsp0_result, eres);
    chk({tag, " rem"}, id ? rsp1_rem : rsp0_rem, erem);
    chk({tag, " flags"}, id ? rsp1_flags : rsp0_flags, eflg);
    cyc();
    chk({tag, " rsp T+5"}, id ? rsp1_valid : rsp0_valid, 0);
    chk({tag, " idle T+5"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; stray = 1'b0; unit_delay = 1;
    req0_valid = 1'b1; req0_mul = 1'b0; req0_a = 8'd0; req0_b = 8'd0;
    req1_valid = 1'b0; req1_mul = 1'b0; req1_a = 8'd0; req1_b = 8'd0;
    #2;
    chk("reset ready0", req0_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset grant", grant_id, 0);
    chk("reset md_start", md_start, 0);
    chk("reset md_a", md_a, 0);
    chk("reset rsp0_valid", rsp0_valid, 0);
    chk("reset rsp0_result", rsp0_result, 0);
    chk("reset rsp1_flags", rsp1_flags, 0);
    req0_valid = 1'b0;
    cyc(); rst_n = 1'b1;

    nominal("mul12x10", 1'b0, 1'b1, 8'd12, 8'd10, 16'd120, 8'd0, 3'b000);
    nominal("div100by7", 1'b1, 1'b0, 8'd100, 8'd7, 16'd14, 8'd2, 3'b000);
    nominal("mul20x20", 1'b0, 1'b1, 8'd20, 8'd20, 16'h00FF, 8'd0, 3'b001);
    nominal("div50by0", 1'b0, 1'b0, 8'd50, 8'd0, 16'hFFFF, 8'hFF, 3'b010);

    // Stray unit strobe while idle must change nothing.
    cyc(); stray = 1'b1;
    cyc(); stray = 1'b0; #1;
    chk("stray busy", busy, 0);
    chk("stray rsp0", rsp0_valid, 0);
    chk("stray result held", rsp0_result, 16'hFFFF);
    chk("stray flags held", rsp0_flags, 3'b010);

    // Unit never answers: timeout after 8 WAIT cycles.
    unit_delay = 0;
    cyc(); drive(1'b1, 1'b1, 8'd2, 8'd3); #1;
    chk("to ready1", req1_ready, 1);
    cyc(); req1_valid = 1'b0; #1;
    chk("to md_start", md_start, 1);
    repeat (8) cyc();
    chk("to rsp T+9", rsp1_valid, 0);
    chk("to busy T+9", busy, 1);
    cyc();
    chk("to rsp T+10", rsp1_valid, 1);
    chk("to rsp0", rsp0_valid, 0);
    chk("to result", rsp1_result, 16'hFFFF);
    chk("to rem", rsp1_rem, 8'hFF);
    chk("to flags", rsp1_flags, 3'b100);
    cyc();
    chk("to idle", busy, 0);

    // Result arrives on the terminal WAIT cycle: captured, no timeout.
    unit_delay = 7;
    cyc(); drive(1'b0, 1'b1, 8'd5, 8'd6);
    cyc(); req0_valid = 1'b0;
    repeat (8) cyc();
    chk("term rsp T+9", rsp0_valid, 0);
    cyc();
    chk("term rsp T+10", rsp0_valid, 1);
    chk("term result", rsp0_result, 16'd30);
    chk("term flags", rsp0_flags, 3'b000);
    cyc();

    // Contention right after reset: req0 first, req1 accepted at T+5.
    unit_delay = 1;
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); drive(1'b0, 1'b1, 8'd3, 8'd4); drive(1'b1, 1'b0, 8'd9, 8'd2); #1;
    chk("rr ready0", req0_ready, 1);
    chk("rr ready1", req1_ready, 0);
    cyc(); req0_valid = 1'b0; #1;
    chk("rr T+1 ready1", req1_ready, 0);
    chk("rr T+1 grant", grant_id, 0);
    cyc(); cyc();
    chk("rr T+3 ready1", req1_ready, 0);
    cyc();
    chk("rr T+4 rsp0", rsp0_valid, 1);
    chk("rr T+4 result", rsp0_result, 16'd12);
    chk("rr T+4 rsp1", rsp1_valid, 0);
    cyc(); drive(1'b0, 1'b1, 8'd1, 8'd1); #1;
    chk("rr T+5 ready1", req1_ready, 1);
    chk("rr T+5 ready0", req0_ready, 0);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    chk("rr T+6 grant", grant_id, 1);
    chk("rr T+6 md_a", md_a, 8'd9);
    cyc(); cyc(); cyc();
    chk("rr T+9 rsp1", rsp1_valid, 1);
    chk("rr T+9 rsp0", rsp0_valid, 0);
    chk("rr T+9 result", rsp1_result, 16'd4);
    chk("rr T+9 rem", rsp1_rem, 8'd1);
    cyc();
    chk("rr T+10 idle", busy, 0);

    // Reset during WAIT drops the operation.
    cyc(); drive(1'b0, 1'b1, 8'd7, 8'd8);
    cyc(); req0_valid = 1'b0;
    cyc();
    chk("rw busy before", busy, 1);
    rst_n = 1'b0; #1;
    chk("rw busy", busy, 0);
    chk("rw md_a", md_a, 0);
    chk("rw md_multiply", md_multiply, 0);
    chk("rw grant", grant_id, 0);
    chk("rw result", rsp0_result, 0);
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rw no rsp0", rsp0_valid, 0);
      chk("rw idle", busy, 0);
    end
    nominal("post reset div", 1'b1, 1'b0, 8'd200, 8'd10, 16'd20, 8'd0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
